// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a prefetch queue between imem and decode.
// Decode redirects flush the queue and fetch the target in the same cycle.
module fetch_queue #(
   parameter int              PC_W     = 10,
   parameter int              INSTR_W  = 32,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [PC_W-1:0]        imem_addr,
   output logic                   imem_req,
   input  logic [INSTR_W-1:0]     imem_rdata,
   input  logic                   redirect,
   input  logic [PC_W-1:0]        redirect_pc,
   input  logic                   deq,
   output logic                   out_valid,
   output logic [INSTR_W-1:0]     out_instr,
   output logic [PC_W-1:0]        out_pc,
   output logic [PC_W-1:0]        out_pcplus1,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PC_W-1:0]    fpc;
   logic               infl;
   logic [PC_W-1:0]    infl_pc;
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic [INSTR_W-1:0] q_instr [DEPTH];
   logic [PC_W-1:0]    q_pc    [DEPTH];

   logic [CW:0] credit;
   logic        room;
   logic        enq;
   logic        pop;

   // Credit counts the in-flight word but not a same-cycle dequeue, so the
   // queue can never be asked to hold more than DEPTH entries.
   assign credit = {1'b0, count} + (CW+1)'(infl);
   assign room   = credit < (CW+1)'(DEPTH);

   assign imem_req  = rst & (redirect | room);
   assign imem_addr = redirect ? redirect_pc : fpc;

   assign enq = infl & ~redirect;
   assign pop = deq & out_valid & ~redirect;

   assign out_valid   = (count != '0);
   assign out_instr   = out_valid ? q_instr[rd_ptr] : '0;
   assign out_pc      = out_valid ? q_pc[rd_ptr] : '0;
   assign out_pcplus1 = out_pc + PC_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc     <= RESET_PC;
         infl    <= 1'b0;
         infl_pc <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
      end else if (redirect) begin
         fpc     <= redirect_pc + PC_W'(1);
         infl    <= 1'b1;
         infl_pc <= redirect_pc;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
      end else begin
         if (room) begin
            fpc     <= fpc + PC_W'(1);
            infl    <= 1'b1;
            infl_pc <= fpc;
         end else begin
            infl <= 1'b0;
         end
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(enq) - CW'(pop);
      end
   end

   // Storage needs no reset: entries are only read while count is nonzero.
   always_ff @(posedge clk) begin
      if (enq) begin
         q_instr[wr_ptr] <= imem_rdata;
         q_pc[wr_ptr]    <= infl_pc;
      end
   end

endmodule
